// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RV32 subset (LW, SW, R-type, BEQ).
// Outputs are decoded from the state register; memory and branch strobes are qualified by their inputs.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALU_Op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       IR_write,
    output logic       PC_write,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        BEQ      = 4'd8,
        TRAP     = 4'd9
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_e     state_q;
    logic [6:0] op_q;
    logic [1:0] rst_sync_q;
    logic       run_s;

    // Reset release synchroniser: assertion is immediate, release lands on the second clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign run_s = rst_sync_q[1];
    assign state = state_q;

    // State register, next-state selection and the opcode latch taken in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= 7'd0;
        end else if (!run_s) begin
            state_q <= FETCH;
            op_q    <= 7'd0;
        end else begin
            case (state_q)
                FETCH:    state_q <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_R:         state_q <= EXECR;
                        OP_BEQ:       state_q <= BEQ;
                        default:      state_q <= TRAP;
                    endcase
                end
                MEMADR:   state_q <= (op_q == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  state_q <= mem_ready ? MEMWB : MEMREAD;
                MEMWB:    state_q <= FETCH;
                MEMWRITE: state_q <= mem_ready ? FETCH : MEMWRITE;
                EXECR:    state_q <= ALUWB;
                ALUWB:    state_q <= FETCH;
                BEQ:      state_q <= FETCH;
                TRAP:     state_q <= TRAP;
                // Unreachable encodings are treated as a fault and parked in TRAP.
                default:  state_q <= TRAP;
            endcase
        end
    end

    // Output decode; everything is held at zero until the synchronised reset releases.
    always_comb begin
        ALU_Op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        IR_write   = 1'b0;
        PC_write   = 1'b0;
        reg_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (run_s) begin
            case (state_q)
                FETCH: begin
                    mem_read   = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    IR_write   = mem_ready;
                    PC_write   = mem_ready;
                end
                DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                MEMREAD:  mem_read = 1'b1;
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                MEMWRITE: begin
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                EXECR: begin
                    alu_src_a = 2'b10;
                    ALU_Op    = 2'b10;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BEQ: begin
                    alu_src_a  = 2'b10;
                    ALU_Op     = 2'b01;
                    PC_write   = zero;
                    instr_done = 1'b1;
                end
                TRAP:     illegal = 1'b1;
                default:  illegal = 1'b1;
            endcase
        end else begin
            mem_read = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scenario bench for multicycle_control: per-cycle expected output vectors go through a scoreboard queue.
module tb_multicycle_control;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] ALU_Op, alu_src_a, alu_src_b, result_src;
    logic       mem_read, mem_write, IR_write, PC_write, reg_write, instr_done, illegal;
    logic [3:0] state;

    logic [18:0] exp_q [$];
    logic [18:0] obs;
    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .ALU_Op(ALU_Op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .mem_read(mem_read), .mem_write(mem_write), .IR_write(IR_write), .PC_write(PC_write),
        .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    assign obs = {state, ALU_Op, alu_src_a, alu_src_b, result_src,
                  mem_read, mem_write, IR_write, PC_write, reg_write, instr_done, illegal};

    // Expected output vector for a state: {state, ALU_Op, src_a, src_b, result_src, mr, mw, ir, pc, rw, done, illegal}
    function automatic logic [18:0] exp_for(int st, logic rdy, logic z);
        case (st)
            0: return {4'd0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0};
            1: return {4'd1, 2'b00, 2'b01, 2'b01, 2'b00, 7'b0000000};
            2: return {4'd2, 2'b00, 2'b10, 2'b01, 2'b00, 7'b0000000};
            3: return {4'd3, 8'b00000000, 7'b1000000};
            4: return {4'd4, 2'b00, 2'b00, 2'b00, 2'b01, 7'b0000110};
            5: return {4'd5, 8'b00000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0};
            6: return {4'd6, 2'b10, 2'b10, 2'b00, 2'b00, 7'b0000000};
            7: return {4'd7, 8'b00000000, 7'b0000110};
            8: return {4'd8, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b1, 1'b0};
            9: return {4'd9, 8'b00000000, 7'b0000001};
            default: return 19'd0;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic test_reset();
        logic [18:0] e;
        #2 rst_n = 1'b0;
        mem_ready = 1'b1;
        #2;
        exp_q.push_back(19'd0);
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL reset_hold got %h expected %h", obs, e); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back((i == 2) ? exp_for(0, 1'b0, 1'b0) : 19'd0);
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL reset_release cyc %0d got %h expected %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_rtype();
        int   st [5] = '{0, 1, 6, 7, 0};
        logic rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [18:0] e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = OP_R; mem_ready = rd[i]; zero = 1'b0;
            exp_q.push_back(exp_for(st[i], rd[i], 1'b0));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL rtype cyc %0d got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_lw();
        int         st [8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [6:0] op [8] = '{OP_LW, OP_LW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
        logic [18:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opcode = op[i]; mem_ready = rd[i]; zero = 1'b1;
            exp_q.push_back(exp_for(st[i], rd[i], 1'b1));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL lw_wait cyc %0d got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_sw();
        int         st [7] = '{0, 0, 1, 2, 5, 5, 0};
        logic       rd [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [6:0] op [7] = '{OP_SW, OP_SW, OP_SW, OP_LW, OP_LW, OP_LW, OP_LW};
        logic [18:0] e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            opcode = op[i]; mem_ready = rd[i]; zero = 1'b0;
            exp_q.push_back(exp_for(st[i], rd[i], 1'b0));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL sw_wait cyc %0d got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_beq();
        int   st [4] = '{0, 1, 8, 0};
        logic rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic zv [2] = '{1'b1, 1'b0};
        logic z;
        logic [18:0] e;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                z = (st[i] == 8) ? zv[r] : ~zv[r];
                opcode = OP_BEQ; mem_ready = rd[i]; zero = z;
                exp_q.push_back(exp_for(st[i], rd[i], z));
                #1;
                e = exp_q.pop_front();
                vectors++;
                if (obs !== e) begin errors++; $display("FAIL beq_z%0d cyc %0d got %h expected %h", zv[r], i, obs, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int         st [8] = '{0, 1, 6, 7, 0, 1, 8, 0};
        logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       zz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [6:0] op [8] = '{OP_R, OP_R, OP_R, OP_R, OP_BEQ, OP_BEQ, OP_BEQ, OP_BEQ};
        logic [18:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            opcode = op[i]; mem_ready = rd[i]; zero = zz[i];
            exp_q.push_back(exp_for(st[i], rd[i], zz[i]));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL b2b cyc %0d got %h expected %h", i, obs, e); end
        end
    endtask

    task automatic test_reset_midwait();
        int   st [5] = '{0, 1, 2, 5, 5};
        logic rd [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [18:0] e;
        logic id_seen;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = OP_SW; mem_ready = rd[i]; zero = 1'b0;
            exp_q.push_back(exp_for(st[i], rd[i], 1'b0));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL midwait cyc %0d got %h expected %h", i, obs, e); end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({mem_write, obs} !== 20'd0) begin
            errors++; $display("FAIL midwait_async mem_write=%b outputs=%h expected all 0", mem_write, obs);
        end
        id_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (instr_done) id_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (instr_done) id_seen = 1'b1;
        end
        #1;
        vectors++;
        if ({state, mem_read, id_seen} !== {4'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL midwait_release state=%0d mem_read=%b done_seen=%b expected 0/1/0", state, mem_read, id_seen);
        end
    endtask

    task automatic test_random();
        logic prev_id = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0: opcode = OP_LW;
                1: opcode = OP_SW;
                2: opcode = OP_R;
                default: opcode = OP_BEQ;
            endcase
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (mem_read && mem_write) begin errors++; $display("FAIL rand_excl cyc %0d mem_read=%b mem_write=%b expected not both", i, mem_read, mem_write); end
            vectors++;
            if (instr_done && prev_id) begin errors++; $display("FAIL rand_done cyc %0d instr_done=1 twice in a row, expected single pulse", i); end
            vectors++;
            if (state > 4'd8) begin errors++; $display("FAIL rand_state cyc %0d state=%0d expected <= 8", i, state); end
            prev_id = instr_done;
        end
    endtask

    task automatic test_trap();
        int st;
        logic rd;
        logic [18:0] e;
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            st = (i == 0) ? 0 : (i == 1) ? 1 : 9;
            rd = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode = (i == 1) ? OP_BAD : OP_R; mem_ready = rd; zero = 1'b0;
            exp_q.push_back(exp_for(st, rd, 1'b0));
            #1;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin errors++; $display("FAIL trap cyc %0d got %h expected %h", i, obs, e); end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== 19'd0) begin errors++; $display("FAIL trap_reset got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        e = exp_for(0, 1'b0, 1'b0);
        vectors++;
        if (obs !== e) begin errors++; $display("FAIL trap_recover got %h expected %h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_beq();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        test_trap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  async active-low reset; low forces state to FETCH at once.
REQ-004 opcode  input  7  instr[6:0] from the instruction register; sampled only in DECODE.
REQ-005 zero  input  1  ALU zero flag; sampled only in BEQ.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_read/mem_write request.
REQ-007 ALU_Op  output  2  00 add, 01 subtract, 10 R-type decode; feeds the ALU function decoder.
REQ-008 alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1.
REQ-009 alu_src_b  output  2  00 rs2, 01 imm, 10 constant 4.
REQ-010 result_src  output  2  00 ALUOut register, 01 memory data, 10 ALU result.
REQ-011 mem_read, mem_write, IR_write, PC_write, reg_write  output  1 each  datapath strobes.
REQ-012 instr_done  output  1  one-cycle pulse when an instruction retires.
REQ-013 illegal  output  1  sticky flag for an unsupported opcode.
REQ-014 state  output  4  current state encoding, for debug.

Function
REQ-015 The FSM SHALL use these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, BEQ 8, TRAP 9.
REQ-016 Outputs SHALL be Moore-decoded from state, except the strobes that REQ-017, REQ-020, REQ-021 and REQ-024 qualify by an input; every output not listed for a state is 0.
REQ-017 FETCH: mem_read=1, alu_src_a=00, alu_src_b=10, ALU_Op=00, result_src=10; IR_write=PC_write=mem_ready; go to DECODE on mem_ready, otherwise hold.
REQ-018 DECODE: alu_src_a=01, alu_src_b=01, ALU_Op=00 (branch target into ALUOut); next state by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 1100011 -> BEQ, any other -> TRAP.
REQ-019 MEMADR: alu_src_a=10, alu_src_b=01, ALU_Op=00; go to MEMREAD if the opcode latched at DECODE is LW, MEMWRITE if SW.
REQ-020 MEMREAD: mem_read=1, result_src=00; go to MEMWB on mem_ready, otherwise hold.
REQ-021 MEMWRITE: mem_write=1, result_src=00; go to FETCH on mem_ready, with instr_done=mem_ready.
REQ-022 MEMWB: result_src=01, reg_write=1, instr_done=1; then go to FETCH.
REQ-023 EXECR: alu_src_a=10, alu_src_b=00, ALU_Op=10; then ALUWB. ALUWB: result_src=00, reg_write=1, instr_done=1; then FETCH.
REQ-024 BEQ: alu_src_a=10, alu_src_b=00, ALU_Op=01, result_src=00, PC_write=zero, instr_done=1; then FETCH.
REQ-025 TRAP: all strobes 0, illegal=1; the FSM SHALL stay in TRAP until reset.
REQ-026 The block SHALL latch opcode into an internal register in DECODE, so later opcode changes do not alter the path.
REQ-027 Latency with mem_ready tied high SHALL be: BEQ 3 cycles, R-type 4, SW 4, LW 5 (FETCH through retire); each memory wait cycle adds 1.
REQ-028 mem_read and mem_write SHALL stay asserted and stable until mem_ready; they SHALL never be asserted together.
REQ-029 mem_ready outside FETCH, MEMREAD and MEMWRITE SHALL be ignored.

Reset
REQ-030 While rst_n=0, all outputs SHALL be 0, state SHALL be 0, illegal SHALL be cleared, and the latched opcode SHALL be cleared.
REQ-031 Reset asserted in any state, including mid-wait, SHALL abort that state; in the first cycle after release the FSM SHALL be in FETCH with mem_read=1.
REQ-032 Reset release SHALL be synchronised internally: deassertion takes effect on the second rising clk edge after rst_n goes high.

Verification
REQ-033 R-type: opcode=0110011, mem_ready=1 -> state sequence 0,1,6,7,0; ALU_Op=10 in state 6; reg_write and instr_done pulse in state 7.
REQ-034 LW with 2 wait cycles in MEMREAD -> mem_read high for 3 cycles in state 3, then state 4 with result_src=01 and reg_write=1; 7 cycles total.
REQ-035 BEQ: zero=1 gives PC_write=1 in state 8 with ALU_Op=01; rerun with zero=0 gives PC_write=0; both return to state 0.
REQ-036 Opcode 1111111 -> DECODE then TRAP; illegal=1 and held for more than 10 cycles; rst_n pulse clears illegal and returns to FETCH.
REQ-037 rst_n dropped while in MEMWRITE with mem_ready=0 -> mem_write falls immediately (asynchronously); after release state=0 and no instr_done has pulsed.
REQ-038 Random opcode/mem_ready stream -> assert mem_read and mem_write are never both 1, and instr_done is never high in consecutive cycles.
